// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] BLANK    = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    // Smallest digit count d with 10^d > 2^width - 1.
    function automatic int unsigned min_digits(input int unsigned width);
        longint unsigned max_val;
        longint unsigned pow;
        int unsigned     d;
        max_val = (64'd1 << width) - 64'd1;
        pow     = 64'd10;
        d       = 1;
        while (pow <= max_val) begin
            pow = pow * 64'd10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/Hex7Segment.sv
// Hex digit to active-low 7-segment decoder (gfedcba); only built with BCD_SEG7_EN.
`ifdef BCD_SEG7_EN
module Hex7Segment (
    input  logic [3:0] hex,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'b1111111;
        case (hex)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0010000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            default: seg_c = 7'b0001110;
        endcase
    end

endmodule
`endif

// File: rtl/bcd_adj3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    assign adj_c = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Multi-cycle double-dabble binary-to-BCD converter, one input bit per clock.
// Define BCD_SEG7_EN to add registered active-low 7-segment outputs (seg_out).
module seq_bin_to_bcd
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 8,
    parameter int unsigned DIGITS    = 3
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd_out
`ifdef BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]    seg_out
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    if (BIN_WIDTH < 4 || BIN_WIDTH > 20) begin : g_bad_width
        $error("seq_bin_to_bcd: BIN_WIDTH must be within 4..20");
    end
    if (DIGITS < min_digits(BIN_WIDTH)) begin : g_bad_digits
        $error("seq_bin_to_bcd: DIGITS too small for BIN_WIDTH");
    end

    state_t               state;
    logic [BCD_W-1:0]     scratch;
    logic [BCD_W-1:0]     adj;
    logic [BCD_W-1:0]     scratch_nxt;
    logic [BIN_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]     cnt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_adj3 u_adj (
            .digit (scratch[4*i +: 4]),
            .adj_c (adj[4*i +: 4])
        );
    end

    // Adjusted scratch shifted left, taking the next binary MSB as its LSB.
    assign scratch_nxt = {adj[BCD_W-2:0], shreg[BIN_WIDTH-1]};

`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_raw;
    logic [7*DIGITS-1:0] seg_nxt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        Hex7Segment u_seg (
            .hex   (scratch_nxt[4*i +: 4]),
            .seg_c (seg_raw[7*i +: 7])
        );
    end

    // Blank leading zeros from the top digit down; digit 0 always shows.
    always_comb begin
        logic lead;
        seg_nxt = seg_raw;
        lead    = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            lead = lead & (scratch_nxt[4*i +: 4] == 4'd0);
            if (lead) seg_nxt[7*i +: 7] = BLANK;
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
`ifdef BCD_SEG7_EN
            seg_out <= {{(DIGITS-1){BLANK}}, SEG_ZERO};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_WIDTH);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd_out <= scratch_nxt;
`ifdef BCD_SEG7_EN
                        seg_out <= seg_nxt;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed bench for seq_bin_to_bcd (8-bit/3-digit and 6-bit/2-digit instances)
// with a queue scoreboard of expected BCD results popped on each done pulse.
module tb_seq_bin_to_bcd;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy, done;
    logic [11:0] bcd_out;
    logic        start6 = 1'b0;
    logic [5:0]  bin6 = 6'd0;
    logic        busy6, done6;
    logic [7:0]  bcd6;
`ifdef BCD_SEG7_EN
    logic [20:0] seg_out;
    logic [13:0] seg6;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  exp6_q[$];

    seq_bin_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
`ifdef BCD_SEG7_EN
        ,
        .seg_out (seg_out)
`endif
    );

    seq_bin_to_bcd #(.BIN_WIDTH(6), .DIGITS(2)) dut6 (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start6),
        .bin_in  (bin6),
        .busy    (busy6),
        .done    (done6),
        .bcd_out (bcd6)
`ifdef BCD_SEG7_EN
        ,
        .seg_out (seg6)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Present start for one edge from a negedge; returns at the negedge after acceptance.
    task automatic kick(input int v);
        @(negedge clock);
        start  = 1'b1;
        bin_in = 8'(v);
        exp_q.push_back(to_bcd(v));
        @(negedge clock);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = n;
                return;
            end
            if (busy) bcnt++;
            @(negedge clock);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (resetn) begin
            logic [11:0] e;
            logic [7:0]  e6;
            check("busy_done_excl", 64'(busy & done), 64'd0);
            check("busy_done_excl6", 64'(busy6 & done6), 64'd0);
            if (done) begin
                done_cnt++;
                check("done_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bcd_out", 64'(bcd_out), 64'(e));
                end
            end
            if (done6) begin
                check("done6_expected", 64'(exp6_q.size() != 0), 64'd1);
                if (exp6_q.size() != 0) begin
                    e6 = exp6_q.pop_front();
                    check("bcd6_out", 64'(bcd6), 64'(e6));
                end
            end
        end
    end

    initial begin
        int lat, bcnt, d0, last, n;
        logic [11:0] t;

        // Reset state
        #1 resetn = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
`ifdef BCD_SEG7_EN
        check("rst_seg", 64'(seg_out), 64'({7'h7f, 7'h7f, 7'b1000000}));
`endif
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // Max value: 8 busy cycles, done after 8 edges, then low
        kick(255);
        wait_done(lat, bcnt);
        check("max_latency", 64'(lat), 64'd8);
        check("max_busy_cycles", 64'(bcnt), 64'd8);
        @(negedge clock);
        check("max_done_low", 64'(done), 64'd0);
        check("max_hold", 64'(bcd_out), 64'h255);

        // Start while busy is ignored
        d0 = done_cnt;
        kick(100);
        repeat (2) @(negedge clock);
        start  = 1'b1;
        bin_in = 8'd7;
        @(negedge clock);
        start  = 1'b0;
        wait_done(lat, bcnt);
        check("busy_start_latency", 64'(lat), 64'd5);
        repeat (15) @(negedge clock);
        check("busy_start_pulses", 64'(done_cnt - d0), 64'd1);
        check("busy_start_bcd", 64'(bcd_out), 64'h100);

        // Reset mid-conversion clears outputs immediately
        kick(200);
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_bcd", 64'(bcd_out), 64'd0);
`ifdef BCD_SEG7_EN
        check("midrst_seg", 64'(seg_out), 64'({7'h7f, 7'h7f, 7'b1000000}));
`endif
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        kick(9);
        wait_done(lat, bcnt);
        check("post_rst_latency", 64'(lat), 64'd8);
        @(negedge clock);
        check("post_rst_bcd", 64'(bcd_out), 64'h009);

        // Hold: bin_in wanders without start
        kick(42);
        wait_done(lat, bcnt);
        check("hold_latency", 64'(lat), 64'd8);
        for (int i = 0; i < 20; i++) begin
            bin_in = 8'($urandom);
            @(negedge clock);
            check("hold_bcd", 64'(bcd_out), 64'h042);
            check("hold_done", 64'(done), 64'd0);
        end

`ifdef BCD_SEG7_EN
        kick(5);
        wait_done(lat, bcnt);
        check("seg_5", 64'(seg_out), 64'({7'h7f, 7'h7f, 7'b0010010}));
        kick(105);
        wait_done(lat, bcnt);
        check("seg_105", 64'(seg_out), 64'({7'b1111001, 7'b1000000, 7'b0010010}));
`endif

        // Narrow instance: back-to-back sweep 0..63, one result per 7 cycles
        @(negedge clock);
        start6 = 1'b1;
        bin6   = 6'd0;
        t = to_bcd(0);
        exp6_q.push_back(t[7:0]);
        last = -1;
        for (int v = 1; v <= 64; v++) begin
            n = 0;
            @(negedge clock);
            while (!done6 && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("narrow_done", 64'(done6), 64'd1);
            if (last >= 0) check("narrow_period", 64'(cyc - last), 64'd7);
            last = cyc;
            if (v < 64) begin
                bin6 = 6'(v);
                t = to_bcd(v);
                exp6_q.push_back(t[7:0]);
            end else begin
                start6 = 1'b0;
            end
        end
        repeat (10) @(negedge clock);
        check("narrow_last", 64'(bcd6), 64'h63);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("queue6_empty", 64'(exp6_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
